// File: rtl/memory_port_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, grant ids,
// and the wait-counter width helper.
package memory_port_arbiter_pkg;

    localparam logic [1:0] STATE_ARB_IDLE    = 2'd0;
    localparam logic [1:0] STATE_ARB_ACCESS  = 2'd1;
    localparam logic [1:0] STATE_ARB_RESPOND = 2'd2;

    localparam logic GRANT_CORE   = 1'b0;
    localparam logic GRANT_LOADER = 1'b1;

    // Counter must hold WAIT_STATES but never collapse to zero bits.
    function automatic int cnt_width(input int wait_states);
        return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
    endfunction

endpackage

// File: rtl/round_robin_pick.sv
// Two-way round-robin pick between the core and loader ports; purely
// combinational, the arbiter FSM decides when the pick is consumed.
module round_robin_pick
    import memory_port_arbiter_pkg::*;
(
    input  logic core_req,
    input  logic ldr_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = core_req | ldr_req;
    // On a tie the port that was not served last wins.
    assign grant_id = (core_req && ldr_req) ? ~last_grant :
                      (ldr_req ? GRANT_LOADER : GRANT_CORE);

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates the single instruction/data memory between the multicycle core
// and the program loader, with a fixed number of wait states per access.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_ready,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  ldr_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = cnt_width(WAIT_STATES);

    logic [1:0]            state;
    logic                  owner;
    logic                  last_grant;
    logic [CW-1:0]         cnt;
    logic                  grant_valid;
    logic                  grant_id;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    round_robin_pick u_pick (
        .core_req   (core_req),
        .ldr_req    (ldr_req),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    assign sel_we    = (grant_id == GRANT_LOADER) ? ldr_we    : core_we;
    assign sel_addr  = (grant_id == GRANT_LOADER) ? ldr_addr  : core_addr;
    assign sel_wdata = (grant_id == GRANT_LOADER) ? ldr_wdata : core_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= STATE_ARB_IDLE;
            owner      <= GRANT_CORE;
            last_grant <= GRANT_LOADER;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            core_rdata <= '0;
            ldr_rdata  <= '0;
            core_ready <= 1'b0;
            ldr_ready  <= 1'b0;
        end else begin
            core_ready <= 1'b0;
            ldr_ready  <= 1'b0;
            case (state)
                STATE_ARB_IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_id;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_we;
                        mem_re    <= ~sel_we;
                        cnt       <= CW'(WAIT_STATES);
                        state     <= STATE_ARB_ACCESS;
                    end
                end
                STATE_ARB_ACCESS: begin
                    if (cnt == '0) begin
                        // Memory data is valid on the last access cycle only.
                        if (mem_re) begin
                            if (owner == GRANT_LOADER) ldr_rdata <= mem_rdata;
                            else                       core_rdata <= mem_rdata;
                        end
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= STATE_ARB_RESPOND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STATE_ARB_RESPOND: begin
                    core_ready <= (owner == GRANT_CORE);
                    ldr_ready  <= (owner == GRANT_LOADER);
                    last_grant <= owner;
                    state      <= STATE_ARB_IDLE;
                end
                default: state <= STATE_ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: one instance with two wait states and one
// with none, ready events scoreboarded against expected port/data/cycle.
module tb_memory_port_arbiter;

    typedef struct packed {
        logic        dut;
        logic        port;
        logic [31:0] rdata;
        logic [31:0] cyc;
    } ev_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] cyc = 32'd0;

    logic        a_core_req, a_core_we, a_core_ready, a_ldr_req, a_ldr_we, a_ldr_ready;
    logic [31:0] a_core_addr, a_core_wdata, a_core_rdata, a_ldr_addr, a_ldr_wdata, a_ldr_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_re, a_mem_we;
    logic        b_core_req, b_core_we, b_core_ready, b_ldr_req, b_ldr_we, b_ldr_ready;
    logic [31:0] b_core_addr, b_core_wdata, b_core_rdata, b_ldr_addr, b_ldr_wdata, b_ldr_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_re, b_mem_we;

    int  n_checks = 0;
    int  n_fail = 0;
    int  obs_rd = 0;
    ev_t exp_q[$];
    ev_t obs[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 32'd1;

    function automatic logic [31:0] mem_val(input logic [31:0] addr);
        case (addr)
            32'h10:  return 32'hDEADBEEF;
            32'h20:  return 32'h11111111;
            32'h30:  return 32'h22222222;
            32'h00:  return 32'hA0A0A0A0;
            32'h04:  return 32'hB1B1B1B1;
            default: return addr ^ 32'h5A5A5A5A;
        endcase
    endfunction

    assign a_mem_rdata = mem_val(a_mem_addr);
    assign b_mem_rdata = mem_val(b_mem_addr);

    memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(2)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .core_req(a_core_req), .core_we(a_core_we), .core_addr(a_core_addr),
        .core_wdata(a_core_wdata), .core_rdata(a_core_rdata), .core_ready(a_core_ready),
        .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr),
        .ldr_wdata(a_ldr_wdata), .ldr_rdata(a_ldr_rdata), .ldr_ready(a_ldr_ready),
        .mem_addr(a_mem_addr), .mem_re(a_mem_re), .mem_we(a_mem_we),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .core_req(b_core_req), .core_we(b_core_we), .core_addr(b_core_addr),
        .core_wdata(b_core_wdata), .core_rdata(b_core_rdata), .core_ready(b_core_ready),
        .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr),
        .ldr_wdata(b_ldr_wdata), .ldr_rdata(b_ldr_rdata), .ldr_ready(b_ldr_ready),
        .mem_addr(b_mem_addr), .mem_re(b_mem_re), .mem_we(b_mem_we),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Every cycle a ready is high becomes one observed event.
    always @(negedge clock) begin
        if (a_core_ready) obs.push_back('{1'b0, 1'b0, a_core_rdata, cyc});
        if (a_ldr_ready)  obs.push_back('{1'b0, 1'b1, a_ldr_rdata, cyc});
        if (b_core_ready) obs.push_back('{1'b1, 1'b0, b_core_rdata, cyc});
        if (b_ldr_ready)  obs.push_back('{1'b1, 1'b1, b_ldr_rdata, cyc});
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] c0;
        int strobes;
        @(negedge clock);
        n_checks++;
        if ({a_mem_re, a_mem_we, a_core_ready, a_ldr_ready, b_mem_re, b_mem_we, b_core_ready, b_ldr_ready} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl got %b %b %b %b want 0", a_mem_re, a_mem_we, a_core_ready, a_ldr_ready);
        end
        n_checks++;
        if ({a_core_rdata, a_ldr_rdata, a_mem_addr, a_mem_wdata} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h %h want 0", a_core_rdata, a_ldr_rdata, a_mem_addr, a_mem_wdata);
        end
        n_checks++;
        if ({b_core_rdata, b_ldr_rdata, b_mem_addr, b_mem_wdata} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data_b got %h %h %h %h want 0", b_core_rdata, b_ldr_rdata, b_mem_addr, b_mem_wdata);
        end
        reset_n = 1'b1;
        strobes = 0;
        repeat (4) begin
            @(negedge clock);
            strobes += int'(a_mem_re) + int'(a_mem_we) + int'(b_mem_re) + int'(b_mem_we);
        end
        n_checks++;
        if (strobes != 0) begin n_fail++; $display("FAIL idle_strobes got %0d want 0", strobes); end
        c0 = cyc;
        n_checks++;
        if (obs.size() != obs_rd) begin n_fail++; $display("FAIL idle_ready got %0d events want %0d", obs.size(), obs_rd); end
        obs_rd = obs.size();
    endtask

    task automatic test_core_read();
        logic [31:0] c0;
        int re_n, we_n, bad_addr;
        ev_t e, o;
        re_n = 0; we_n = 0; bad_addr = 0;
        @(negedge clock);
        a_core_req = 1'b1; a_core_we = 1'b0; a_core_addr = 32'h10;
        c0 = cyc + 32'd1;
        exp_q.push_back('{1'b0, 1'b0, 32'hDEADBEEF, c0 + 32'd4});
        repeat (10) begin
            @(negedge clock);
            if (cyc == c0) a_core_req = 1'b0;
            if (a_mem_re) begin re_n++; if (a_mem_addr !== 32'h10) bad_addr++; end
            if (a_mem_we) we_n++;
        end
        n_checks++;
        if (re_n != 3) begin n_fail++; $display("FAIL read_re_cycles got %0d want 3", re_n); end
        n_checks++;
        if (bad_addr != 0 || we_n != 0) begin n_fail++; $display("FAIL read_addr_we got bad_addr=%0d we=%0d want 0 0", bad_addr, we_n); end
        n_checks++;
        if (a_core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata_hold got %h want deadbeef", a_core_rdata); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd < obs.size()) ? obs[obs_rd] : '0;
            obs_rd++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL read_ready got %p want %p", o, e); end
        end
        n_checks++;
        if (obs.size() != obs_rd) begin n_fail++; $display("FAIL read_extra got %0d events want %0d", obs.size(), obs_rd); end
        obs_rd = obs.size();
    endtask

    task automatic test_round_robin();
        logic [31:0] c0;
        ev_t e, o;
        do_reset();
        @(negedge clock);
        a_core_req = 1'b1; a_core_we = 1'b0; a_core_addr = 32'h20;
        a_ldr_req = 1'b1;  a_ldr_we = 1'b0;  a_ldr_addr = 32'h30;
        c0 = cyc + 32'd1;
        exp_q.push_back('{1'b0, 1'b0, 32'h11111111, c0 + 32'd4});
        exp_q.push_back('{1'b0, 1'b1, 32'h22222222, c0 + 32'd9});
        exp_q.push_back('{1'b0, 1'b0, 32'h11111111, c0 + 32'd14});
        repeat (20) begin
            @(negedge clock);
            if (cyc == c0 + 32'd5)  a_ldr_req = 1'b0;
            if (cyc == c0 + 32'd10) a_core_req = 1'b0;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd < obs.size()) ? obs[obs_rd] : '0;
            obs_rd++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rr_ready got %p want %p", o, e); end
        end
        n_checks++;
        if (obs.size() != obs_rd) begin n_fail++; $display("FAIL rr_extra got %0d events want %0d", obs.size(), obs_rd); end
        obs_rd = obs.size();
    endtask

    task automatic test_loader_write();
        logic [31:0] c0;
        int we_n, re_n, bad;
        ev_t e, o;
        we_n = 0; re_n = 0; bad = 0;
        @(negedge clock);
        a_ldr_req = 1'b1; a_ldr_we = 1'b1; a_ldr_addr = 32'h20; a_ldr_wdata = 32'h0000CAFE;
        c0 = cyc + 32'd1;
        exp_q.push_back('{1'b0, 1'b1, 32'h22222222, c0 + 32'd4});
        repeat (10) begin
            @(negedge clock);
            if (cyc == c0) a_ldr_req = 1'b0;
            if (a_mem_we) begin
                we_n++;
                if (a_mem_wdata !== 32'h0000CAFE || a_mem_addr !== 32'h20) bad++;
            end
            if (a_mem_re) re_n++;
        end
        n_checks++;
        if (we_n != 3) begin n_fail++; $display("FAIL write_we_cycles got %0d want 3", we_n); end
        n_checks++;
        if (bad != 0 || re_n != 0) begin n_fail++; $display("FAIL write_bus got bad=%0d re=%0d want 0 0", bad, re_n); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd < obs.size()) ? obs[obs_rd] : '0;
            obs_rd++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL write_ready got %p want %p", o, e); end
        end
        n_checks++;
        if (obs.size() != obs_rd) begin n_fail++; $display("FAIL write_extra got %0d events want %0d", obs.size(), obs_rd); end
        obs_rd = obs.size();
    endtask

    task automatic test_back_to_back();
        logic [31:0] c0;
        int re_n;
        ev_t e, o;
        re_n = 0;
        @(negedge clock);
        b_core_req = 1'b1; b_core_we = 1'b0; b_core_addr = 32'h0;
        c0 = cyc + 32'd1;
        exp_q.push_back('{1'b1, 1'b0, 32'hA0A0A0A0, c0 + 32'd2});
        exp_q.push_back('{1'b1, 1'b0, 32'hB1B1B1B1, c0 + 32'd5});
        repeat (10) begin
            @(negedge clock);
            if (cyc == c0) b_core_addr = 32'h4;
            if (cyc == c0 + 32'd3) b_core_req = 1'b0;
            if (b_mem_re) re_n++;
        end
        n_checks++;
        if (re_n != 2) begin n_fail++; $display("FAIL b2b_re_cycles got %0d want 2", re_n); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd < obs.size()) ? obs[obs_rd] : '0;
            obs_rd++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_ready got %p want %p", o, e); end
        end
        n_checks++;
        if (obs.size() != obs_rd) begin n_fail++; $display("FAIL b2b_extra got %0d events want %0d", obs.size(), obs_rd); end
        obs_rd = obs.size();
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] c0;
        int we_n;
        ev_t e, o;
        we_n = 0;
        @(negedge clock);
        a_core_req = 1'b1; a_core_we = 1'b1; a_core_addr = 32'h40; a_core_wdata = 32'h00005555;
        c0 = cyc + 32'd1;
        @(negedge clock);
        n_checks++;
        if (a_mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_we_before got %b want 1", a_mem_we); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({a_mem_we, a_core_ready} !== 2'b00) begin n_fail++; $display("FAIL midrst_async got we=%b ready=%b want 0 0", a_mem_we, a_core_ready); end
        a_core_req = 1'b0; a_core_we = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (a_mem_we) we_n++;
        end
        n_checks++;
        if (we_n != 0) begin n_fail++; $display("FAIL midrst_we_after got %0d want 0", we_n); end
        // A fresh read with normal latency shows the FSM came back in IDLE.
        a_core_req = 1'b1; a_core_addr = 32'h10;
        c0 = cyc + 32'd1;
        exp_q.push_back('{1'b0, 1'b0, 32'hDEADBEEF, c0 + 32'd4});
        repeat (10) begin
            @(negedge clock);
            if (cyc == c0) a_core_req = 1'b0;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd < obs.size()) ? obs[obs_rd] : '0;
            obs_rd++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL midrst_ready got %p want %p", o, e); end
        end
        n_checks++;
        if (obs.size() != obs_rd) begin n_fail++; $display("FAIL midrst_extra got %0d events want %0d", obs.size(), obs_rd); end
        obs_rd = obs.size();
    endtask

    task automatic test_drop_req();
        logic [31:0] c0;
        int re_n;
        ev_t e, o;
        re_n = 0;
        @(negedge clock);
        a_core_req = 1'b1; a_core_we = 1'b0; a_core_addr = 32'h24;
        c0 = cyc + 32'd1;
        exp_q.push_back('{1'b0, 1'b0, 32'h24 ^ 32'h5A5A5A5A, c0 + 32'd4});
        repeat (14) begin
            @(negedge clock);
            if (cyc == c0) a_core_req = 1'b0;
            if (a_mem_re) re_n++;
        end
        n_checks++;
        if (re_n != 3) begin n_fail++; $display("FAIL drop_re_cycles got %0d want 3", re_n); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd < obs.size()) ? obs[obs_rd] : '0;
            obs_rd++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL drop_ready got %p want %p", o, e); end
        end
        n_checks++;
        if (obs.size() != obs_rd) begin n_fail++; $display("FAIL drop_extra got %0d events want %0d", obs.size(), obs_rd); end
        obs_rd = obs.size();
    endtask

    initial begin
        a_core_req = 1'b0; a_core_we = 1'b0; a_core_addr = '0; a_core_wdata = '0;
        a_ldr_req = 1'b0;  a_ldr_we = 1'b0;  a_ldr_addr = '0;  a_ldr_wdata = '0;
        b_core_req = 1'b0; b_core_we = 1'b0; b_core_addr = '0; b_core_wdata = '0;
        b_ldr_req = 1'b0;  b_ldr_we = 1'b0;  b_ldr_addr = '0;  b_ldr_wdata = '0;
        test_reset();
        test_core_read();
        test_round_robin();
        test_loader_write();
        test_back_to_back();
        test_reset_mid_write();
        test_drop_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
